ip_header_csum_insert: RTL and testbench

//  Downstream companion to the IPv4 checksum stage. It buffers one IPv4 header
//  (20-60 bytes), computes the ones'-complement header checksum, and re-emits the

---
 rtl/ip_header_csum_insert.sv | 154 +++++++++++++++
 tb/tb_ip_header_csum_insert.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ip_header_csum_insert.sv
// rtl/ip_header_csum_insert.sv - buffers one IPv4 header, computes its checksum and
// re-emits the header with the checksum field substituted.
module ip_header_csum_insert #(
  parameter int AXIS_BYTES = 2,
  parameter int MAX_WORDS  = 30,
  parameter int CSUM_WORD  = 5
) (
  input  logic        clk,
  input  logic        areset,
  output logic        axis_i_tready,
  input  logic        axis_i_tvalid,
  input  logic        axis_i_tlast,
  input  logic [1:0]  axis_i_tkeep,
  input  logic [15:0] axis_i_tdata,
  input  logic        axis_o_tready,
  output logic        axis_o_tvalid,
  output logic        axis_o_tlast,
  output logic [1:0]  axis_o_tkeep,
  output logic [15:0] axis_o_tdata,
  output logic        axis_o_tuser
);

  if (AXIS_BYTES != 2) begin : g_bad_width
    $error("ip_header_csum_insert supports AXIS_BYTES == 2 only");
  end

  localparam int PW = $clog2(MAX_WORDS + 1);
  localparam logic [PW-1:0] L_MAX  = MAX_WORDS[PW-1:0];
  localparam logic [PW-1:0] L_CSUM = CSUM_WORD[PW-1:0];
  localparam logic [PW-1:0] L_ONE  = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_LOAD, S_FOLD, S_SEND} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_buf  [MAX_WORDS];
  logic [1:0]    r_keep [MAX_WORDS];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [16:0]   r_acc;
  logic [15:0]   r_csum;
  logic          r_ovf;

  logic          w_in_fire;
  logic          w_in_store;
  logic          w_out_fire;
  logic          w_load;
  logic [15:0]   w_masked;
  logic [16:0]   w_acc_next;
  logic [15:0]   w_fold;
  logic [15:0]   w_csum_now;
  logic [15:0]   w_rd_data;
  logic          w_rd_last;
  logic          w_short;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    axis_i_tready = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      S_LOAD: begin
        axis_i_tready = 1'b1;
        if (axis_i_tvalid && axis_i_tlast) w_next = S_FOLD;
      end
      S_FOLD: begin
        w_load = 1'b1;
        w_next = S_SEND;
      end
      S_SEND: begin
        if (w_out_fire && axis_o_tlast) w_next = S_LOAD;
        else if (w_out_fire)            w_load = 1'b1;
      end
      default: w_next = S_LOAD;
    endcase
  end

  assign w_in_fire  = axis_i_tvalid && axis_i_tready;
  assign w_in_store = w_in_fire && (r_wr_ptr < L_MAX);
  assign w_out_fire = axis_o_tvalid && axis_o_tready;

  // The checksum field itself never contributes, regardless of its input value.
  always_comb begin
    w_masked = axis_i_tdata & {{8{axis_i_tkeep[1]}}, {8{axis_i_tkeep[0]}}};
    if (r_wr_ptr == L_CSUM) w_masked = 16'h0000;
  end

  assign w_acc_next = {1'b0, w_masked} + {1'b0, r_acc[15:0]} + {16'h0000, r_acc[16]};
  assign w_fold     = ~(r_acc[15:0] + {15'h0000, r_acc[16]});
  assign w_csum_now = (r_state == S_FOLD) ? w_fold : r_csum;
  assign w_short    = (r_wr_ptr <= L_CSUM);
  assign w_rd_last  = (r_rd_ptr == r_wr_ptr - L_ONE);
  assign w_rd_data  = (r_rd_ptr == L_CSUM) ? w_csum_now : r_buf[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_in_store) begin
      r_buf[r_wr_ptr]  <= axis_i_tdata;
      r_keep[r_wr_ptr] <= axis_i_tkeep;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_acc    <= '0;
      r_csum   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_in_store) begin
        r_wr_ptr <= r_wr_ptr + L_ONE;
        r_acc    <= w_acc_next;
      end else if (w_in_fire) begin
        r_ovf    <= 1'b1;
      end
      if (r_state == S_FOLD) r_csum <= w_fold;
      if (w_load) r_rd_ptr <= r_rd_ptr + L_ONE;
      if (w_out_fire && axis_o_tlast) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_acc    <= '0;
        r_ovf    <= 1'b0;
      end
    end
  end

  // Output beat register: loads the next word on FOLD and on each non-final handshake.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      axis_o_tvalid <= 1'b0;
      axis_o_tlast  <= 1'b0;
      axis_o_tuser  <= 1'b0;
      axis_o_tdata  <= '0;
      axis_o_tkeep  <= '0;
    end else if (w_load) begin
      axis_o_tvalid <= 1'b1;
      axis_o_tlast  <= w_rd_last;
      axis_o_tuser  <= w_rd_last && (r_ovf || w_short);
      axis_o_tdata  <= w_rd_data;
      axis_o_tkeep  <= r_keep[r_rd_ptr];
    end else if (w_out_fire) begin
      axis_o_tvalid <= 1'b0;
      axis_o_tlast  <= 1'b0;
      axis_o_tuser  <= 1'b0;
      axis_o_tdata  <= '0;
      axis_o_tkeep  <= '0;
    end
  end

endmodule

// File: tb/tb_ip_header_csum_insert.sv
// tb/tb_ip_header_csum_insert.sv - scoreboard bench for ip_header_csum_insert.
module tb_ip_header_csum_insert;

  logic        clk = 1'b0;
  logic        areset;
  logic        i_tready, i_tvalid, i_tlast;
  logic [1:0]  i_tkeep;
  logic [15:0] i_tdata;
  logic        o_tready, o_tvalid, o_tlast, o_tuser;
  logic [1:0]  o_tkeep;
  logic [15:0] o_tdata;

  ip_header_csum_insert dut (
    .clk(clk), .areset(areset),
    .axis_i_tready(i_tready), .axis_i_tvalid(i_tvalid), .axis_i_tlast(i_tlast),
    .axis_i_tkeep(i_tkeep), .axis_i_tdata(i_tdata),
    .axis_o_tready(o_tready), .axis_o_tvalid(o_tvalid), .axis_o_tlast(o_tlast),
    .axis_o_tkeep(o_tkeep), .axis_o_tdata(o_tdata), .axis_o_tuser(o_tuser)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       prev_beat;
  beat_t       mon_exp;
  logic        prev_stall = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  int          hs_count = 0;
  int          stall_n = 0;
  int          rdy_mode = 0;
  logic [15:0] pkt_w[$];
  logic [1:0]  pkt_k[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && o_tvalid)
        check("stall_hold", {12'h0, o_tdata, o_tkeep, o_tlast, o_tuser}, {12'h0, prev_beat});
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_beat: got %h expected no beat", o_tdata);
        end else begin
          mon_exp = exp_q.pop_front();
          check($sformatf("beat%0d", hs_count),
                {12'h0, o_tdata, o_tkeep, o_tlast, o_tuser}, {12'h0, mon_exp});
        end
        hs_count++;
      end
      prev_stall = o_tvalid && !o_tready;
      prev_beat  = {o_tdata, o_tkeep, o_tlast, o_tuser};
    end
  end

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) o_tready = 1'b1;
      else if (hs_count == 5 && stall_n < 5) begin
        o_tready = 1'b0;
        stall_n++;
      end else o_tready = ~o_tready;
    end
  end

  task automatic load_hdr(input logic [15:0] w5);
    pkt_w = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
              w5, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};
    pkt_k = {};
    for (int i = 0; i < 10; i++) pkt_k.push_back(2'b11);
  endtask

  task automatic send_pkt(input logic [15:0] csum, input logic user, input int abort_at);
    int    n;
    int    stored;
    int    t;
    beat_t b;
    n = pkt_w.size();
    stored = (n > 30) ? 30 : n;
    for (int i = 0; i < stored; i++) begin
      b.d = (i == 5 && stored > 5) ? csum : pkt_w[i];
      b.k = pkt_k[i];
      b.l = (i == stored - 1);
      b.u = (i == stored - 1) ? user : 1'b0;
      exp_q.push_back(b);
    end
    hs_count = 0;
    stall_n  = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      i_tvalid = 1'b1;
      i_tdata  = pkt_w[i];
      i_tkeep  = pkt_k[i];
      i_tlast  = (i == n - 1);
      if (!i_tready) check("in_tready", {31'h0, i_tready}, 32'h1);
      @(posedge clk);
      #1;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    check("fold_tready", {31'h0, i_tready}, 32'h0);
    check("fold_tvalid", {31'h0, o_tvalid}, 32'h0);
    @(posedge clk);
    #1;
    check("first_beat_n2", {31'h0, o_tvalid}, 32'h1);
    if (abort_at >= 0) begin
      t = 0;
      while (hs_count != abort_at && t < 100) begin
        @(posedge clk);
        #2;
        t++;
      end
      check("abort_reach", hs_count, abort_at);
      areset = 1'b1;
      #1;
      check("abort_tvalid", {31'h0, o_tvalid}, 32'h0);
      exp_q.delete();
      @(posedge clk);
      #2;
      areset = 1'b0;
      check("abort_tready", {31'h0, i_tready}, 32'h1);
    end else begin
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
        @(posedge clk);
        t++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
      check("tready_back", {31'h0, i_tready}, 32'h1);
      check("tvalid_idle", {31'h0, o_tvalid}, 32'h0);
    end
  endtask

  initial begin
    areset   = 1'b1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    i_tkeep  = 2'b00;
    i_tdata  = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", {31'h0, o_tvalid}, 32'h0);
    check("rst_tlast",  {31'h0, o_tlast},  32'h0);
    check("rst_tuser",  {31'h0, o_tuser},  32'h0);
    check("rst_tdata",  {16'h0, o_tdata},  32'h0);
    check("rst_tkeep",  {30'h0, o_tkeep},  32'h0);
    check("rst_tready", {31'h0, i_tready}, 32'h1);
    areset = 1'b0;

    load_hdr(16'h0000);
    send_pkt(16'hB861, 1'b0, -1);

    load_hdr(16'hFFFF);
    send_pkt(16'hB861, 1'b0, -1);

    rdy_mode = 1;
    load_hdr(16'h0000);
    send_pkt(16'hB861, 1'b0, -1);
    rdy_mode = 0;

    pkt_w = {};
    pkt_k = {};
    for (int i = 0; i < 32; i++) begin
      pkt_w.push_back(16'h0001);
      pkt_k.push_back(2'b11);
    end
    send_pkt(16'hFFE2, 1'b1, -1);

    pkt_w = '{16'h4500, 16'h0014, 16'h0000};
    pkt_k = '{2'b11, 2'b11, 2'b11};
    send_pkt(16'h0000, 1'b1, -1);

    pkt_w = '{16'hABCD};
    pkt_k = '{2'b11};
    send_pkt(16'h0000, 1'b1, -1);

    load_hdr(16'h0000);
    pkt_w.push_back(16'h45AB);
    pkt_k.push_back(2'b10);
    send_pkt(16'h7361, 1'b0, -1);

    load_hdr(16'h0000);
    send_pkt(16'hB861, 1'b0, 4);
    load_hdr(16'h0000);
    send_pkt(16'hB861, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
